dsc_mul_seq_ctrl: RTL and testbench

DSC_MUL_SEQ_CTRL -- requirements
Module: dsc_mul_seq_ctrl

---
 rtl/dsc_ctrl_pkg.sv | 24 ++
 rtl/dsc_sat_counter.sv | 26 ++
 rtl/dsc_mul_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dsc_mul_seq_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_ctrl_pkg.sv
// Shared types and constants for the sequential multiplier controller.
// No logic: state encoding, phase lengths and a phase-terminal helper.
// Used by dsc_mul_seq_ctrl and dsc_sat_counter.
package dsc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam int CLEAR_CYCLES = 2;
  localparam int DRAIN_CYCLES = 1;

  // Wide enough for the longest fixed-length phase (CLEAR).
  localparam int PHASE_W = 2;

  function automatic logic [PHASE_W-1:0] last_phase(input int cycles);
    return PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dsc_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible the cycle after inc; holds at all-ones once reached.
// No backpressure; inc is simply ignored at saturation.
module dsc_sat_counter
  import dsc_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dsc_mul_seq_ctrl.sv
// Job sequencer for a multi-operand multiplier core: latch, clear, run, drain, hold.
// Latency: 2 + N + 1 cycles from input handshake to out_valid (N = RUN cycles).
// One job in flight; in_ready only in IDLE, HOLD waits on out_ready. DSC_MUL_TIMEOUT_EN adds a RUN watchdog.
module dsc_mul_seq_ctrl
  import dsc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int RES_WIDTH  = DATA_WIDTH*NUM_INPUTS+1,
  parameter int CNT_WIDTH  = DATA_WIDTH*NUM_INPUTS+1
`ifdef DSC_MUL_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 2**(DATA_WIDTH*NUM_INPUTS)+4
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic                             core_clr,
  output logic                             core_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
  input  logic                             core_done,
  input  logic [RES_WIDTH-1:0]             core_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RES_WIDTH-1:0]             out_data,
  output logic [CNT_WIDTH-1:0]             run_cycles,
  output logic                             busy
`ifdef DSC_MUL_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 5) begin : g_bad_num_inputs
    $error("dsc_mul_seq_ctrl: NUM_INPUTS must be in 2..5");
  end

  state_t               state;
  logic [PHASE_W-1:0]   phase;
  logic                 run_clr;
  logic                 run_inc;
  logic                 to_hit;

  // Counters restart on the CLEAR->RUN edge so they read zero on the first RUN cycle.
  assign run_clr = (state == CLEAR) && (phase == last_phase(CLEAR_CYCLES));
  assign run_inc = (state == RUN);

  dsc_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (run_inc),
    .cnt (run_cycles)
  );

`ifdef DSC_MUL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_job;

  dsc_sat_counter #(
    .WIDTH (TO_W)
  ) u_to_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (run_inc),
    .cnt (to_cnt)
  );

  // Fires on the TIMEOUT-th RUN cycle; a real done in that same cycle wins.
  assign to_hit = (state == RUN) && !core_done && (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      phase       <= '0;
      in_ready    <= 1'b1;
      core_clr    <= 1'b0;
      core_en     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      core_data   <= '0;
      out_data    <= '0;
`ifdef DSC_MUL_TIMEOUT_EN
      to_job      <= 1'b0;
      timeout_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            core_data <= in_data;
            state     <= CLEAR;
            phase     <= '0;
            in_ready  <= 1'b0;
            core_clr  <= 1'b1;
            busy      <= 1'b1;
          end
        end

        CLEAR: begin
          if (phase == last_phase(CLEAR_CYCLES)) begin
            state    <= RUN;
            core_clr <= 1'b0;
            core_en  <= 1'b1;
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end

        RUN: begin
          if (core_done || to_hit) begin
            state   <= DRAIN;
            phase   <= '0;
            core_en <= 1'b0;
`ifdef DSC_MUL_TIMEOUT_EN
            to_job  <= to_hit;
            if (to_hit) begin
              timeout_err <= 1'b1;
            end
`endif
          end
        end

        DRAIN: begin
          // Core's accumulator settles during DRAIN, so capture at its end.
          if (phase == last_phase(DRAIN_CYCLES)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
`ifdef DSC_MUL_TIMEOUT_EN
            out_data  <= to_job ? {RES_WIDTH{1'b1}} : core_result;
`else
            out_data  <= core_result;
`endif
          end else begin
            phase <= phase + PHASE_W'(1);
          end
        end

        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          phase     <= '0;
          in_ready  <= 1'b1;
          core_clr  <= 1'b0;
          core_en   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq_ctrl.sv
// Directed bench for dsc_mul_seq_ctrl with a behavioural multiplier-core model.
// Build with or without DSC_MUL_TIMEOUT_EN.
module tb_dsc_mul_seq_ctrl;

  localparam int DW = 5;
  localparam int NI = 2;
  localparam int RW = DW*NI+1;
  localparam int CW = DW*NI+1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NI*DW-1:0] in_data = '0;
  logic             core_clr;
  logic             core_en;
  logic [NI*DW-1:0] core_data;
  logic             core_done;
  logic [RW-1:0]    core_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RW-1:0]    out_data;
  logic [CW-1:0]    run_cycles;
  logic             busy;
`ifdef DSC_MUL_TIMEOUT_EN
  logic             timeout_err;
`endif

  always #5 clk = ~clk;

  dsc_mul_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_clr    (core_clr),
    .core_en     (core_en),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .run_cycles  (run_cycles),
    .busy        (busy)
`ifdef DSC_MUL_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // Core model: done on the done_after-th enabled cycle (0 = never), product lands one cycle later.
  int            done_after = 0;
  logic          done_force = 1'b0;
  logic [15:0]   mcnt = '0;
  logic [RW-1:0] acc = '0;
  logic [RW-1:0] prod;

  assign prod        = RW'(core_data[DW-1:0]) * RW'(core_data[2*DW-1:DW]);
  assign core_done   = done_force | (core_en && (done_after != 0) && (int'(mcnt) == done_after - 1));
  assign core_result = acc;

  always @(posedge clk) begin
    if (core_clr) begin
      mcnt <= '0;
      acc  <= '0;
    end else if (core_en) begin
      mcnt <= mcnt + 16'd1;
      if (core_done) acc <= prod;
    end
  end

  int   cyc = 0, clr_hi = 0, clr_rise = 0, hs_cnt = 0, rdy_hi = 0, out_cnt = 0;
  logic clr_q = 1'b0;
  logic [RW-1:0] out_q[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_q <= core_clr;
    if (core_clr) clr_hi <= clr_hi + 1;
    if (core_clr && !clr_q) clr_rise <= clr_rise + 1;
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (in_ready) rdy_hi <= rdy_hi + 1;
    if (out_valid && out_ready) begin
      out_cnt <= out_cnt + 1;
      out_q.push_back(out_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cyc   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL start_job_in_ready: in_ready=%0b after %0d cycles, want 1", in_ready, n);
    end
    in_valid = 1'b1;
    in_data  = {b, a};
    tick();
    in_valid = 1'b0;
    hs_cyc   = cyc;
  endtask

  task automatic wait_out(input int limit, output int lat);
    int n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    lat = cyc - hs_cyc;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_low_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_low_busy: got %0b want 0", busy); end
    rst = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (core_clr !== 1'b0) begin n_fail++; $display("FAIL rst_core_clr: got %0b want 0", core_clr); end
    n_checks++; if (core_en !== 1'b0) begin n_fail++; $display("FAIL rst_core_en: got %0b want 0", core_en); end
    n_checks++; if (core_data !== '0) begin n_fail++; $display("FAIL rst_core_data: got %0h want 0", core_data); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    n_checks++; if (run_cycles !== '0) begin n_fail++; $display("FAIL rst_run_cycles: got %0d want 0", run_cycles); end
`ifdef DSC_MUL_TIMEOUT_EN
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %0b want 0", timeout_err); end
`endif
    repeat (2) tick();
    n_checks++; if (clr_hi !== 0) begin n_fail++; $display("FAIL rst_no_clr_pulse: clr cycles %0d want 0", clr_hi); end
  endtask

  task automatic test_job;
    int lat, c0;
    done_after = 256;
    c0 = clr_hi;
    start_job(5'd5, 5'd7);
    n_checks++; if (core_data !== {5'd7, 5'd5}) begin n_fail++; $display("FAIL job_core_data: got %0h want %0h", core_data, {5'd7, 5'd5}); end
    n_checks++; if (core_clr !== 1'b1 || core_en !== 1'b0) begin n_fail++; $display("FAIL job_clear1: clr=%0b en=%0b want 1/0", core_clr, core_en); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL job_busy: in_ready=%0b busy=%0b want 0/1", in_ready, busy); end
    tick();
    n_checks++; if (core_clr !== 1'b1 || core_en !== 1'b0) begin n_fail++; $display("FAIL job_clear2: clr=%0b en=%0b want 1/0", core_clr, core_en); end
    tick();
    n_checks++; if (core_clr !== 1'b0 || core_en !== 1'b1) begin n_fail++; $display("FAIL job_run: clr=%0b en=%0b want 0/1", core_clr, core_en); end
    wait_out(400, lat);
    n_checks++; if (lat !== 259) begin n_fail++; $display("FAIL job_latency: got %0d want 259", lat); end
    n_checks++; if (out_data !== 11'd35) begin n_fail++; $display("FAIL job_out_data: got %0d want 35", out_data); end
    n_checks++; if (run_cycles !== 11'd256) begin n_fail++; $display("FAIL job_run_cycles: got %0d want 256", run_cycles); end
    n_checks++; if (clr_hi - c0 !== 2) begin n_fail++; $display("FAIL job_clr_cycles: got %0d want 2", clr_hi - c0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL job_release: ov=%0b ir=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy); end
  endtask

  task automatic test_backpressure;
    int lat;
    done_after = 5;
    start_job(5'd3, 5'd4);
    wait_out(50, lat);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", lat); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {5'd31, 5'd31};
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, out_valid); end
      n_checks++; if (out_data !== 11'd12) begin n_fail++; $display("FAIL bp_out_data[%0d]: got %0d want 12", i, out_data); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    n_checks++; if (core_data !== {5'd4, 5'd3}) begin n_fail++; $display("FAIL bp_core_data: got %0h want %0h", core_data, {5'd4, 5'd3}); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: ov=%0b ir=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy); end
  endtask

  task automatic test_spurious;
    int lat;
    done_after = 20;
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || core_en !== 1'b0) begin n_fail++; $display("FAIL sp_idle_done: busy=%0b ir=%0b en=%0b want 0/1/0", busy, in_ready, core_en); end
    start_job(5'd2, 5'd9);
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    n_checks++; if (core_clr !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL sp_clear_done: clr=%0b busy=%0b want 1/1", core_clr, busy); end
    tick();
    n_checks++; if (core_en !== 1'b1 || core_clr !== 1'b0) begin n_fail++; $display("FAIL sp_run_entry: en=%0b clr=%0b want 1/0", core_en, core_clr); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = {5'd31, 5'd31};
      tick();
      n_checks++; if (core_data !== {5'd9, 5'd2}) begin n_fail++; $display("FAIL sp_core_data[%0d]: got %0h want %0h", i, core_data, {5'd9, 5'd2}); end
    end
    in_valid = 1'b0;
    wait_out(100, lat);
    n_checks++; if (lat !== 23) begin n_fail++; $display("FAIL sp_latency: got %0d want 23", lat); end
    n_checks++; if (out_data !== 11'd18) begin n_fail++; $display("FAIL sp_out_data: got %0d want 18", out_data); end
    n_checks++; if (run_cycles !== 11'd20) begin n_fail++; $display("FAIL sp_run_cycles: got %0d want 20", run_cycles); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int lat, c0;
    done_after = 300;
    start_job(5'd6, 5'd6);
    while (cyc - hs_cyc < 100) tick();
    n_checks++; if (run_cycles !== 11'd98 || core_en !== 1'b1) begin n_fail++; $display("FAIL mr_pre: run_cycles=%0d en=%0b want 98/1", run_cycles, core_en); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || core_clr !== 1'b0 || core_en !== 1'b0) begin n_fail++; $display("FAIL mr_ctl: ir=%0b clr=%0b en=%0b want 1/0/0", in_ready, core_clr, core_en); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mr_status: ov=%0b busy=%0b want 0/0", out_valid, busy); end
    n_checks++; if (core_data !== '0 || out_data !== '0 || run_cycles !== '0) begin n_fail++; $display("FAIL mr_data: cd=%0h od=%0h rc=%0d want 0/0/0", core_data, out_data, run_cycles); end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (core_clr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mr_release: clr=%0b busy=%0b want 0/0", core_clr, busy); end
    c0 = clr_hi;
    done_after = 10;
    start_job(5'd3, 5'd5);
    wait_out(100, lat);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL mr_next_latency: got %0d want 13", lat); end
    n_checks++; if (out_data !== 11'd15) begin n_fail++; $display("FAIL mr_next_out_data: got %0d want 15", out_data); end
    n_checks++; if (run_cycles !== 11'd10) begin n_fail++; $display("FAIL mr_next_run_cycles: got %0d want 10", run_cycles); end
    n_checks++; if (clr_hi - c0 !== 2) begin n_fail++; $display("FAIL mr_next_clr_cycles: got %0d want 2", clr_hi - c0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int hs0, rdy0, clr0, rise0, out0, seen;
    logic [NI*DW-1:0] vec[3];
    vec[0] = {5'd3, 5'd2};
    vec[1] = {5'd5, 5'd4};
    vec[2] = {5'd7, 5'd6};
    done_after = 4;
    out_q.delete();
    hs0 = hs_cnt; rdy0 = rdy_hi; clr0 = clr_hi; rise0 = clr_rise; out0 = out_cnt;
    seen = hs_cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vec[0];
    for (int i = 0; i < 27; i++) begin
      tick();
      if (hs_cnt != seen) begin
        seen = hs_cnt;
        if (hs_cnt - hs0 < 3) in_data = vec[hs_cnt - hs0];
      end
    end
    n_checks++; if (hs_cnt - hs0 !== 3) begin n_fail++; $display("FAIL b2b_handshakes: got %0d want 3", hs_cnt - hs0); end
    n_checks++; if (rdy_hi - rdy0 !== 3) begin n_fail++; $display("FAIL b2b_in_ready_cycles: got %0d want 3", rdy_hi - rdy0); end
    n_checks++; if (clr_hi - clr0 !== 6) begin n_fail++; $display("FAIL b2b_clr_cycles: got %0d want 6", clr_hi - clr0); end
    n_checks++; if (clr_rise - rise0 !== 3) begin n_fail++; $display("FAIL b2b_clr_pulses: got %0d want 3", clr_rise - rise0); end
    n_checks++; if (out_cnt - out0 !== 3) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 3", out_cnt - out0); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (out_q.size() >= 3) begin
      n_checks++; if (out_q[0] !== 11'd6) begin n_fail++; $display("FAIL b2b_res0: got %0d want 6", out_q[0]); end
      n_checks++; if (out_q[1] !== 11'd20) begin n_fail++; $display("FAIL b2b_res1: got %0d want 20", out_q[1]); end
      n_checks++; if (out_q[2] !== 11'd42) begin n_fail++; $display("FAIL b2b_res2: got %0d want 42", out_q[2]); end
    end else begin
      n_checks++; n_fail++;
      $display("FAIL b2b_result_count: got %0d want 3", out_q.size());
    end
  endtask

  task automatic test_timeout;
`ifdef DSC_MUL_TIMEOUT_EN
    int lat;
    done_after = 0;
    start_job(5'd1, 5'd1);
    wait_out(1200, lat);
    n_checks++; if (lat !== 1031) begin n_fail++; $display("FAIL to_latency: got %0d want 1031", lat); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0b want 1", timeout_err); end
    n_checks++; if (out_data !== 11'h7FF) begin n_fail++; $display("FAIL to_out_data: got %0h want 7ff", out_data); end
    n_checks++; if (run_cycles !== 11'd1028) begin n_fail++; $display("FAIL to_run_cycles: got %0d want 1028", run_cycles); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: ir=%0b err=%0b want 1/1", in_ready, timeout_err); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_cleared: got %0b want 0", timeout_err); end
`else
    done_after = 0;
    start_job(5'd1, 5'd1);
    repeat (1100) tick();
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || core_en !== 1'b1) begin n_fail++; $display("FAIL nto_wait: busy=%0b ov=%0b en=%0b want 1/0/1", busy, out_valid, core_en); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL nto_recover: busy=%0b ir=%0b want 0/1", busy, in_ready); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_job();
    test_backpressure();
    test_spurious();
    test_reset_midrun();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
